decoder2to4_pipe: RTL and testbench

- Registered 2-to-4 one-hot decoder with valid/ready handshakes on both sides and an internal FIFO buffer.
- Input is a 2-bit binary code. Output is the matching 4-bit one-hot word: 2'b00→4'b0001, 01→0010, 10→0100, 11→1000.
- Sits downstream of the 4-to-2 encode path and restores one-hot select lines for consumers that may stall.
- Also keeps a saturating count of delivered words for debug.

---
 rtl/dec_pkg.sv | 13 +
 rtl/decoder2to4_pipe_if.sv | 23 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/decoder2to4_pipe.sv | 53 +++++
 tb/tb_decoder2to4_pipe.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared widths, constants and the 2-to-4 one-hot decode function
package dec_pkg;

    localparam int ONEHOT_W = 4;
    localparam int CODE_W   = 2;

    localparam logic [ONEHOT_W-1:0] ONEHOT_NONE = 4'b0000;

    function automatic logic [ONEHOT_W-1:0] onehot2(input logic [CODE_W-1:0] code);
        return ONEHOT_W'(1) << code;
    endfunction

endpackage

// File: rtl/decoder2to4_pipe_if.sv
// rtl/decoder2to4_pipe_if.sv - upstream code and downstream one-hot handshake bundle
interface decoder2to4_pipe_if;
    import dec_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [CODE_W-1:0]   in;
    logic                en;
    logic                out_valid;
    logic                out_ready;
    logic [ONEHOT_W-1:0] out;

    modport master (
        output in_valid, in, en, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, in, en, out_ready,
        output in_ready, out_valid, out
    );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, power-of-two depth, occupancy-counted full/empty
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses pushes even when a pop frees a slot the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

endmodule

// File: rtl/decoder2to4_pipe.sv
// rtl/decoder2to4_pipe.sv - buffered 2-to-4 one-hot decoder with valid/ready on both sides
module decoder2to4_pipe
    import dec_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    decoder2to4_pipe_if.slave  bus,
    output logic [CNT_W-1:0]   xfer_cnt
);

    logic                push;
    logic                pop;
    logic                empty;
    logic                full;
    logic [ONEHOT_W-1:0] word;
    logic [ONEHOT_W-1:0] dout;

    // Decode before storage so the buffer holds finished select words.
    assign word = bus.en ? onehot2(bus.in) : ONEHOT_NONE;

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out       = empty ? ONEHOT_NONE : dout;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    sync_fifo #(
        .WIDTH (ONEHOT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (word),
        .pop   (pop),
        .dout  (dout),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (pop && (xfer_cnt != '1)) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decoder2to4_pipe.sv
// tb/tb_decoder2to4_pipe.sv - directed self-checking bench for decoder2to4_pipe
module tb_decoder2to4_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] xfer_cnt;
    logic [1:0] sat_cnt;
    int         total  = 0;
    int         passed = 0;

    always #5 clk = ~clk;

    decoder2to4_pipe_if bus ();
    decoder2to4_pipe_if sbus ();

    decoder2to4_pipe #(.DEPTH(2), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .xfer_cnt (xfer_cnt)
    );

    decoder2to4_pipe #(.DEPTH(2), .CNT_W(2)) dut_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (sbus),
        .xfer_cnt (sat_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        logic [3:0] stream_exp [4];
        logic [1:0] sat_exp    [5];
        stream_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        sat_exp    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in = 2'b00; bus.en = 1'b1; bus.out_ready = 1'b0;
        sbus.in_valid = 1'b0; sbus.in = 2'b00; sbus.en = 1'b1; sbus.out_ready = 1'b0;
        #3;
        check("reset_out_valid", {7'd0, bus.out_valid}, 8'd0);
        check("reset_out", {4'd0, bus.out}, 8'h00);
        check("reset_in_ready", {7'd0, bus.in_ready}, 8'd1);
        check("reset_xfer_cnt", xfer_cnt, 8'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // single code 2 with immediate drain
        bus.in_valid = 1'b1; bus.in = 2'b10; bus.en = 1'b1; bus.out_ready = 1'b1;
        tick();
        check("single_valid", {7'd0, bus.out_valid}, 8'd1);
        check("single_out", {4'd0, bus.out}, 8'h04);
        bus.in_valid = 1'b0;
        tick();
        check("single_drained", {7'd0, bus.out_valid}, 8'd0);
        check("single_cnt", xfer_cnt, 8'd1);

        // back-to-back codes 0..3
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in = 2'(i);
            tick();
            check($sformatf("stream_out_%0d", i), {4'd0, bus.out}, {4'd0, stream_exp[i]});
            check($sformatf("stream_ready_%0d", i), {7'd0, bus.in_ready}, 8'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        check("stream_drained", {7'd0, bus.out_valid}, 8'd0);
        check("stream_cnt", xfer_cnt, 8'd5);

        // fill under backpressure, third push refused
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in = 2'b01;
        tick();
        check("fill1_ready", {7'd0, bus.in_ready}, 8'd1);
        check("fill1_out", {4'd0, bus.out}, 8'h02);
        bus.in = 2'b11;
        tick();
        check("fill2_ready", {7'd0, bus.in_ready}, 8'd0);
        check("fill2_hold", {4'd0, bus.out}, 8'h02);
        bus.in = 2'b00;
        tick();
        check("fill3_ready", {7'd0, bus.in_ready}, 8'd0);
        check("fill3_hold", {4'd0, bus.out}, 8'h02);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick();
        check("drain1_out", {4'd0, bus.out}, 8'h08);
        check("drain1_valid", {7'd0, bus.out_valid}, 8'd1);
        tick();
        check("drain2_valid", {7'd0, bus.out_valid}, 8'd0);
        check("drain_cnt", xfer_cnt, 8'd7);

        // push+pop while full, then push+pop while partial
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in = 2'b10;
        tick();
        bus.in = 2'b01;
        tick();
        bus.in = 2'b11; bus.out_ready = 1'b1;
        tick();
        check("fullpp_out", {4'd0, bus.out}, 8'h02);
        check("fullpp_ready", {7'd0, bus.in_ready}, 8'd1);
        tick();
        check("partpp_out", {4'd0, bus.out}, 8'h08);
        check("partpp_ready", {7'd0, bus.in_ready}, 8'd1);
        bus.in_valid = 1'b0;
        tick();
        check("pp_drained", {7'd0, bus.out_valid}, 8'd0);
        check("pp_cnt", xfer_cnt, 8'd10);

        // decode disabled yields an all-zero but valid word
        bus.en = 1'b0; bus.in = 2'b01; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        tick();
        check("en0_valid", {7'd0, bus.out_valid}, 8'd1);
        check("en0_out", {4'd0, bus.out}, 8'h00);
        bus.in_valid = 1'b0; bus.en = 1'b1; bus.out_ready = 1'b1;
        tick();
        check("en0_drained", {7'd0, bus.out_valid}, 8'd0);
        check("en0_cnt", xfer_cnt, 8'd11);

        // asynchronous reset with two words buffered
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in = 2'b00;
        tick();
        bus.in = 2'b01;
        tick();
        check("prerst_valid", {7'd0, bus.out_valid}, 8'd1);
        check("prerst_ready", {7'd0, bus.in_ready}, 8'd0);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {7'd0, bus.out_valid}, 8'd0);
        check("midrst_ready", {7'd0, bus.in_ready}, 8'd1);
        check("midrst_cnt", xfer_cnt, 8'd0);
        check("midrst_out", {4'd0, bus.out}, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();

        // counter saturation on the narrow-counter instance
        sbus.out_ready = 1'b1; sbus.in_valid = 1'b1; sbus.en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sbus.in = 2'(i);
            tick();
            check($sformatf("sat_cnt_%0d", i), {6'd0, sat_cnt}, {6'd0, sat_exp[i]});
        end
        sbus.in_valid = 1'b0;
        tick();
        check("sat_final_cnt", {6'd0, sat_cnt}, 8'd3);
        check("sat_final_valid", {7'd0, sbus.out_valid}, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
